// File: rtl/decode_stage.sv
// Single-slot RV32I decode stage: registers the decoded fields, format code and
// XLEN-wide sign-extended immediate behind a valid/ready handshake with flush.
module decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_inst,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       out_opcode,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_func3,
   output logic [6:0]       out_func7,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] dec_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   state_e            state_q, state_d;
   logic [31:0]       inst_q;
   fmt_e              fmt_q, fmt_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;
   logic              load;
   logic              sgn;

   assign in_ready = ((state_q == EMPTY) || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign sgn      = in_inst[31];

   // Decode of the incoming word; only captured on accept.
   always_comb begin
      fmt_d     = FMT_ILL;
      imm_d     = '0;
      illegal_d = 1'b1;
      if (in_inst[1:0] == 2'b11) begin
         illegal_d = 1'b0;
         case (in_inst[6:0])
            7'b0110011: fmt_d = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
               fmt_d = FMT_I;
               imm_d = {{(XLEN-12){sgn}}, in_inst[31:20]};
            end
            7'b0100011: begin
               fmt_d = FMT_S;
               imm_d = {{(XLEN-12){sgn}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
               fmt_d = FMT_B;
               imm_d = {{(XLEN-13){sgn}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
               fmt_d = FMT_U;
               // bit 31 folded into the replication so XLEN=32 needs no zero-width term
               imm_d = {{(XLEN-31){sgn}}, in_inst[30:12], 12'b0};
            end
            7'b1101111: begin
               fmt_d = FMT_J;
               imm_d = {{(XLEN-21){sgn}}, in_inst[31], in_inst[19:12],
                        in_inst[20], in_inst[30:21], 1'b0};
            end
            default: begin
               fmt_d     = FMT_ILL;
               illegal_d = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         if (accept) begin
            state_d = FULL;
            load    = 1'b1;
         end else if (out_ready) begin
            state_d = EMPTY;
         end
         if ((state_q == FULL) && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         inst_q    <= '0;
         fmt_q     <= FMT_R;
         imm_q     <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            inst_q    <= in_inst;
            fmt_q     <= fmt_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
         end
      end
   end

   assign out_valid   = (state_q == FULL);
   assign out_opcode  = inst_q[6:0];
   assign out_rd      = inst_q[11:7];
   assign out_rs1     = inst_q[19:15];
   assign out_rs2     = inst_q[24:20];
   assign out_func3   = inst_q[14:12];
   assign out_func7   = inst_q[31:25];
   assign out_imm     = imm_q;
   assign out_fmt     = fmt_q;
   assign out_illegal = illegal_q;
   assign dec_count   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: XLEN=32 and XLEN=64 instances share stimulus.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_inst;
   logic        flush;
   logic        out_ready;

   logic        rdy32, val32, ill32;
   logic [6:0]  op32, f7_32;
   logic [4:0]  rd32, rs1_32, rs2_32;
   logic [2:0]  f3_32, fmt32;
   logic [31:0] imm32;
   logic [15:0] cnt32;

   logic        rdy64, val64, ill64;
   logic [6:0]  op64, f7_64;
   logic [4:0]  rd64, rs1_64, rs2_64;
   logic [2:0]  f3_64, fmt64;
   logic [63:0] imm64;
   logic [15:0] cnt64;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  fmt;
      logic [31:0] i32;
      logic [63:0] i64;
      logic        ill;
   } vec_t;
   vec_t vecs [0:11];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .CNT_W(16)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
      .in_ready(rdy32), .flush(flush), .out_valid(val32), .out_ready(out_ready),
      .out_opcode(op32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
      .out_func3(f3_32), .out_func7(f7_32), .out_imm(imm32), .out_fmt(fmt32),
      .out_illegal(ill32), .dec_count(cnt32)
   );

   decode_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
      .in_ready(rdy64), .flush(flush), .out_valid(val64), .out_ready(out_ready),
      .out_opcode(op64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
      .out_func3(f3_64), .out_func7(f7_64), .out_imm(imm64), .out_fmt(fmt64),
      .out_illegal(ill64), .dec_count(cnt64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
      #2;
      total++;
      if (val32 !== 1'b0 || val64 !== 1'b0) begin
         $display("FAIL reset_valid got=%b/%b exp=0", val32, val64); bad++;
      end
      total++;
      if (cnt32 !== 16'd0 || imm64 !== 64'd0 || op32 !== 7'd0 || fmt32 !== 3'd0) begin
         $display("FAIL reset_outs cnt=%h imm=%h op=%h fmt=%h exp=0", cnt32, imm64, op32, fmt32);
         bad++;
      end
      step();
      rst_n = 1'b1;
      #1;
      total++;
      if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
         $display("FAIL reset_in_ready got=%b/%b exp=1", rdy32, rdy64); bad++;
      end
   endtask

   task automatic test_itype();
      in_valid = 1'b1; in_inst = 32'hFFF00093; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      total++;
      if (val32 !== 1'b1 || fmt32 !== 3'd1 || rd32 !== 5'd1 || rs1_32 !== 5'd0 || ill32 !== 1'b0) begin
         $display("FAIL itype_fields valid=%b fmt=%0d rd=%0d rs1=%0d ill=%b exp 1/1/1/0/0",
                  val32, fmt32, rd32, rs1_32, ill32);
         bad++;
      end
      total++;
      if (imm32 !== 32'hFFFFFFFF) begin
         $display("FAIL itype_imm32 got=%h exp=ffffffff", imm32); bad++;
      end
      total++;
      if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
         $display("FAIL itype_imm64 got=%h exp=ffffffffffffffff", imm64); bad++;
      end
   endtask

   task automatic test_formats();
      vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[1]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[2]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
      vecs[3]  = '{32'h0020A423, 3'd2, 32'h00000008, 64'h0000000000000008, 1'b0};
      vecs[4]  = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[5]  = '{32'h002081B3, 3'd0, 32'h00000000, 64'h0000000000000000, 1'b0};
      vecs[6]  = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[7]  = '{32'h008000EF, 3'd5, 32'h00000008, 64'h0000000000000008, 1'b0};
      vecs[8]  = '{32'h00000000, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
      vecs[9]  = '{32'h0000007F, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
      vecs[10] = '{32'h12345017, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
      vecs[11] = '{32'hFFF00092, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
      for (int i = 0; i < 12; i++) begin
         // out_ready=1 so each new word replaces the held bundle
         in_valid = 1'b1; in_inst = vecs[i].inst; out_ready = 1'b1;
         step();
         in_valid = 1'b0; out_ready = 1'b0;
         total++;
         if (val32 !== 1'b1 || fmt32 !== vecs[i].fmt || ill32 !== vecs[i].ill ||
             fmt64 !== vecs[i].fmt || ill64 !== vecs[i].ill) begin
            $display("FAIL fmt_vec%0d inst=%h fmt=%0d/%0d ill=%b/%b valid=%b exp fmt=%0d ill=%b",
                     i, vecs[i].inst, fmt32, fmt64, ill32, ill64, val32, vecs[i].fmt, vecs[i].ill);
            bad++;
         end
         total++;
         if (imm32 !== vecs[i].i32 || imm64 !== vecs[i].i64) begin
            $display("FAIL imm_vec%0d inst=%h got=%h/%h exp=%h/%h",
                     i, vecs[i].inst, imm32, imm64, vecs[i].i32, vecs[i].i64);
            bad++;
         end
         total++;
         if (op32 !== vecs[i].inst[6:0]) begin
            $display("FAIL opcode_vec%0d got=%h exp=%h", i, op32, vecs[i].inst[6:0]); bad++;
         end
      end
   endtask

   task automatic test_back_to_back();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; out_ready = 1'b1;
         in_inst = {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13};
         #1;
         total++;
         if (rdy32 !== 1'b1) begin
            $display("FAIL b2b_in_ready%0d got=%b exp=1", i, rdy32); bad++;
         end
         step();
         total++;
         if (val32 !== 1'b1 || rd32 !== 5'(i + 1) || imm32 !== 32'(i) || cnt32 !== 16'(i)) begin
            $display("FAIL b2b_bundle%0d valid=%b rd=%0d imm=%0d cnt=%0d exp 1/%0d/%0d/%0d",
                     i, val32, rd32, imm32, cnt32, i + 1, i, i);
            bad++;
         end
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      total++;
      if (cnt32 !== 16'd8 || cnt64 !== 16'd8 || val32 !== 1'b0) begin
         $display("FAIL b2b_count cnt=%0d/%0d valid=%b exp 8/8/0", cnt32, cnt64, val32); bad++;
      end
   endtask

   task automatic test_stall();
      in_valid = 1'b1; in_inst = 32'h40C5D533; out_ready = 1'b1;
      step();
      in_inst = 32'hFFF00093; out_ready = 1'b0;
      #1;
      total++;
      if (rdy32 !== 1'b0) begin
         $display("FAIL stall_in_ready got=%b exp=0", rdy32); bad++;
      end
      step(); step(); step();
      total++;
      if (val32 !== 1'b1 || op32 !== 7'h33 || rd32 !== 5'hA || f3_32 !== 3'd5 ||
          rs1_32 !== 5'hB || rs2_32 !== 5'hC || f7_32 !== 7'h20 || imm32 !== 32'd0 || fmt32 !== 3'd0) begin
         $display("FAIL stall_hold valid=%b op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h imm=%h fmt=%0d exp 1/33/a/5/b/c/20/0/0",
                  val32, op32, rd32, f3_32, rs1_32, rs2_32, f7_32, imm32, fmt32);
         bad++;
      end
      total++;
      if (cnt32 !== 16'd8) begin
         $display("FAIL stall_count got=%0d exp=8", cnt32); bad++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++;
      if (cnt32 !== 16'd9 || val32 !== 1'b0) begin
         $display("FAIL stall_drain cnt=%0d valid=%b exp 9/0", cnt32, val32); bad++;
      end
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_inst = 32'h008000EF; out_ready = 1'b1;
      step();
      in_inst = 32'h800000B7; out_ready = 1'b0; flush = 1'b1;
      #1;
      total++;
      if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
         $display("FAIL flush_in_ready got=%b/%b exp=0", rdy32, rdy64); bad++;
      end
      step();
      flush = 1'b0; in_valid = 1'b0;
      total++;
      if (val32 !== 1'b0 || cnt32 !== 16'd9) begin
         $display("FAIL flush_stall valid=%b cnt=%0d exp 0/9", val32, cnt32); bad++;
      end
      in_valid = 1'b1; in_inst = 32'h008000EF; out_ready = 1'b1;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (val32 !== 1'b0 || cnt32 !== 16'd9 || cnt64 !== 16'd9) begin
         $display("FAIL flush_ready valid=%b cnt=%0d/%0d exp 0/9/9", val32, cnt32, cnt64); bad++;
      end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_inst = 32'h002081B3; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (val32 !== 1'b0 || val64 !== 1'b0 || cnt32 !== 16'd0 || rd32 !== 5'd0 || op64 !== 7'd0) begin
         $display("FAIL async_reset valid=%b/%b cnt=%0d rd=%0d op=%h exp 0", val32, val64, cnt32, rd32, op64);
         bad++;
      end
      #2;
      rst_n = 1'b1;
      #1;
      total++;
      if (rdy32 !== 1'b1) begin
         $display("FAIL post_reset_ready got=%b exp=1", rdy32); bad++;
      end
      in_valid = 1'b1; in_inst = 32'hFFF00093;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (val32 !== 1'b1 || fmt32 !== 3'd1 || imm32 !== 32'hFFFFFFFF) begin
         $display("FAIL post_reset_accept valid=%b fmt=%0d imm=%h exp 1/1/ffffffff", val32, fmt32, imm32);
         bad++;
      end
      step();
      out_ready = 1'b0;
      total++;
      if (cnt32 !== 16'd1) begin
         $display("FAIL post_reset_count got=%0d exp=1", cnt32); bad++;
      end
   endtask

   initial begin
      test_reset();
      test_itype();
      test_formats();
      test_back_to_back();
      test_stall();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values are 32 and 64 only.
REQ-002 Parameter CNT_W, default 16, width of the decoded-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_inst  input  32  raw instruction word.
REQ-007 in_ready  output  1  stage accepts in_inst this cycle.
REQ-008 flush  input  1  discard the held instruction (branch redirect).
REQ-009 out_valid  output  1  decoded bundle is valid.
REQ-010 out_ready  input  1  execute consumes the bundle this cycle.
REQ-011 out_opcode  output  7  inst[6:0].
REQ-012 out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], inst[19:15], inst[24:20].
REQ-013 out_func3  output  3  inst[14:12]; out_func7  output  7  inst[31:25].
REQ-014 out_imm  output  XLEN  immediate selected by format.
REQ-015 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-016 out_illegal  output  1  instruction is not a recognised RV32I base opcode.
REQ-017 dec_count  output  CNT_W  number of bundles handed to execute since reset.

Function
REQ-018 The stage SHALL be a single registered pipeline slot with states EMPTY and FULL (FULL == out_valid).
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-020 Accept occurs when in_valid && in_ready; the decoded bundle SHALL appear on the outputs the next cycle (latency 1) with out_valid=1.
REQ-021 Transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on simultaneous out_ready and accept (new bundle replaces old, full throughput, no bubble).
REQ-022 While FULL and out_ready=0, all out_* SHALL hold stable.
REQ-023 flush SHALL force EMPTY next cycle, override any accept in the same cycle, and not increment dec_count.
REQ-024 dec_count SHALL increment by 1 on each out_valid && out_ready && !flush cycle, wrapping modulo 2^CNT_W.
REQ-025 Format by opcode: 0110011 R; 0010011, 0000011, 1100111, 0001111, 1110011 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J.
REQ-026 Any other opcode, or inst[1:0] != 2'b11, SHALL set out_illegal=1, out_fmt=7, out_imm=0; field outputs still carry the raw slices.
REQ-027 imm I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); U = sext({inst[31:12],12'b0}); R = 0.
REQ-028 All sign extension SHALL replicate inst[31] up to bit XLEN-1, for both XLEN=32 and XLEN=64.

Reset
REQ-029 On rst_n=0, immediately and regardless of clk: out_valid=0, dec_count=0, all other out_* = 0, state EMPTY.
REQ-030 An instruction held when reset asserts SHALL be lost; after rst_n rises, in_ready=1 on the first cycle.

Verification
REQ-031 XLEN=32, in_inst=0xFFF00093 accepted -> next cycle out_fmt=1, out_rd=1, out_rs1=0, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-032 XLEN=64, in_inst=0xFE000EE3 (beq x0,x0,-4) -> out_fmt=3, out_imm=0xFFFFFFFFFFFFFFFC; in_inst=0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000.
REQ-033 Back-to-back valid with out_ready=1 for 8 cycles -> 8 consecutive bundles, no bubbles, dec_count=8; out_ready=0 while FULL -> in_ready=0, outputs stable.
REQ-034 in_inst=0x00000000 -> out_illegal=1, out_fmt=7, out_imm=0; in_inst=0x0000007F -> out_illegal=1.
REQ-035 FULL with out_ready=0, assert flush together with in_valid=1 -> next cycle out_valid=0, dec_count unchanged, in_ready=0 during the flush cycle.
REQ-036 rst_n pulsed low mid-cycle while FULL -> out_valid=0 and dec_count=0 before the next clk edge; normal accept resumes after release.
